// File: rtl/rdet_pkg.sv
// Shared definitions for the time-multiplexed rising-edge detector:
// the 2-bit detector state encoding and its next-state / output functions.
package rdet_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RISE = 2'b01,
      ST_HIGH = 2'b10
   } state_t;

   // Next state of the rising-edge detector; the unused code 11 falls back to idle.
   function automatic state_t next_state(input state_t state, input logic w);
      state_t ns;
      case (state)
         ST_IDLE: ns = w ? ST_RISE : ST_IDLE;
         ST_RISE: ns = w ? ST_HIGH : ST_IDLE;
         ST_HIGH: ns = w ? ST_HIGH : ST_IDLE;
         default: ns = ST_IDLE;
      endcase
      return ns;
   endfunction

   // The detector reports a rise only on entry to the rise-seen state.
   function automatic logic rise_z(input state_t ns);
      return (ns == ST_RISE);
   endfunction

endpackage

// File: rtl/rdet_fsm_core.sv
// The single shared rising-edge detector: purely combinational, it maps a
// restored channel state and that channel's sample bit to the state to save
// back and the z output for that sample.
module rdet_fsm_core
   import rdet_pkg::*;
(
   input  logic [1:0] state_in,
   input  logic       w,
   output logic [1:0] state_out,
   output logic       z
);

   state_t ns;

   // Evaluate the detector transition for whichever channel currently owns the core.
   always_comb begin
      ns        = next_state(state_t'(state_in), w);
      state_out = ns;
      z         = rise_z(ns);
   end

endmodule

// File: rtl/rise_detect_scheduler.sv
// Time-multiplexes one rising-edge detector across N_CH serial bit channels.
// Each cycle a round-robin arbiter picks one pending, non-clearing channel,
// restores its saved detector state into the shared core, and at the clock
// edge saves the new state, publishes z, pulses a strobe and bumps a
// saturating rise counter for that channel only.
module rise_detect_scheduler
   import rdet_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CH-1:0]         ch_valid,
   input  logic [N_CH-1:0]         ch_w,
   input  logic [N_CH-1:0]         ch_clr,
   output logic [N_CH-1:0]         ch_ack,
   output logic [N_CH-1:0]         ch_z,
   output logic [N_CH-1:0]         z_strobe,
   output logic [N_CH*CNT_W-1:0]   rise_cnt
);

   localparam int PTR_W = $clog2(N_CH);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_vld;
   logic [N_CH-1:0]  eligible;

   state_t           state_q [N_CH];
   logic [CNT_W-1:0] cnt_q   [N_CH];

   logic [1:0]       core_state_in;
   logic             core_w;
   logic [1:0]       core_state_out;
   logic             core_z;

   // Round-robin search from the pointer upward, wrapping at N_CH; a channel
   // being cleared is never eligible in the same cycle.
   always_comb begin
      int idx;
      idx       = 0;
      eligible  = ch_valid & ~ch_clr;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!grant_vld && eligible[idx]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(idx);
         end
      end
   end

   // One-hot acknowledge in the grant cycle, suppressed while reset is held.
   always_comb begin
      ch_ack = '0;
      if (grant_vld && rst_n) ch_ack[grant_idx] = 1'b1;
   end

   // Restore the granted channel's saved state and sample into the shared core.
   always_comb begin
      core_state_in = state_q[grant_idx];
      core_w        = ch_w[grant_idx];
   end

   rdet_fsm_core u_core (
      .state_in  (core_state_in),
      .w         (core_w),
      .state_out (core_state_out),
      .z         (core_z)
   );

   // Advance the pointer past the granted channel; hold it when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (grant_vld) begin
         if (grant_idx == PTR_W'(N_CH - 1)) ptr_q <= '0;
         else                               ptr_q <= grant_idx + 1'b1;
      end
   end

   // Per-channel context: clear wins, otherwise only the granted channel is updated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i]  <= ST_IDLE;
            cnt_q[i]    <= '0;
            ch_z[i]     <= 1'b0;
            z_strobe[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            z_strobe[i] <= 1'b0;
            if (ch_clr[i]) begin
               state_q[i] <= ST_IDLE;
               cnt_q[i]   <= '0;
               ch_z[i]    <= 1'b0;
            end else if (grant_vld && (grant_idx == PTR_W'(i))) begin
               state_q[i]  <= state_t'(core_state_out);
               ch_z[i]     <= core_z;
               z_strobe[i] <= 1'b1;
               if (core_z && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign rise_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_rise_detect_scheduler.sv
// Directed bench for rise_detect_scheduler: a default instance (N_CH=4,
// CNT_W=8) for the main behaviour and a CNT_W=2 instance for saturation.
module tb_rise_detect_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  ch_valid, ch_w, ch_clr, ch_ack, ch_z, z_strobe;
   logic [31:0] rise_cnt;

   logic [3:0]  s_valid, s_w, s_clr, s_ack, s_z, s_strobe;
   logic [7:0]  s_cnt;

   int total = 0;
   int bad   = 0;

   rise_detect_scheduler #(.N_CH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ch_valid(ch_valid), .ch_w(ch_w), .ch_clr(ch_clr),
      .ch_ack(ch_ack), .ch_z(ch_z), .z_strobe(z_strobe), .rise_cnt(rise_cnt)
   );

   rise_detect_scheduler #(.N_CH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .ch_valid(s_valid), .ch_w(s_w), .ch_clr(s_clr),
      .ch_ack(s_ack), .ch_z(s_z), .z_strobe(s_strobe), .rise_cnt(s_cnt)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic logic [7:0] cntOf(input int i);
      return rise_cnt[i*8 +: 8];
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] w, input logic [3:0] c);
      ch_valid = v;
      ch_w     = w;
      ch_clr   = c;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Hold reset across one edge, confirm the reset state, then release.
   task automatic doReset();
      rst_n = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      s_valid = '0; s_w = '0; s_clr = '0;
      stepCycle();
      checkOutput("rst_ack",    32'(ch_ack),   32'h0);
      checkOutput("rst_z",      32'(ch_z),     32'h0);
      checkOutput("rst_strobe", 32'(z_strobe), 32'h0);
      checkOutput("rst_cnt",    rise_cnt,      32'h0);
      rst_n = 1'b1;
   endtask

   // Directed test sequence.
   initial begin
      logic wseq [7];
      logic zexp [7];
      int   strobes;
      int   acks [4];

      wseq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      zexp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      #2;
      doReset();

      // Single channel 0, one sample per grant.
      strobes = 0;
      for (int k = 0; k < 7; k++) begin
         applyStimulus(4'b0001, {3'b000, wseq[k]}, 4'b0000);
         #1;
         checkOutput($sformatf("t1_ack%0d", k), 32'(ch_ack), 32'h1);
         stepCycle();
         checkOutput($sformatf("t1_z%0d", k), 32'(ch_z[0]), 32'(zexp[k]));
         if (z_strobe == 4'b0001) strobes++;
      end
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      stepCycle();
      checkOutput("t1_strobes",   32'(strobes),  32'd7);
      checkOutput("t1_strobe_off", 32'(z_strobe), 32'h0);
      checkOutput("t1_cnt0",      32'(cntOf(0)), 32'd2);

      // All four channels continuously valid: strict rotation from channel 0.
      doReset();
      for (int i = 0; i < 4; i++) acks[i] = 0;
      applyStimulus(4'b1111, 4'b0000, 4'b0000);
      for (int k = 0; k < 8; k++) begin
         #1;
         checkOutput($sformatf("t2_ack%0d", k), 32'(ch_ack), 32'(1 << (k % 4)));
         for (int i = 0; i < 4; i++) if (ch_ack[i]) acks[i]++;
         stepCycle();
      end
      for (int i = 0; i < 4; i++) checkOutput($sformatf("t2_count%0d", i), 32'(acks[i]), 32'd2);

      // Channels 1 and 3 each send 1,1 interleaved.
      doReset();
      applyStimulus(4'b1010, 4'b1010, 4'b0000);
      #1; checkOutput("t3_ackA", 32'(ch_ack), 32'h2);
      stepCycle();
      checkOutput("t3_zA", 32'(ch_z), 32'h2);
      checkOutput("t3_ackB", 32'(ch_ack), 32'h8);
      stepCycle();
      checkOutput("t3_zB", 32'(ch_z), 32'hA);
      checkOutput("t3_ackC", 32'(ch_ack), 32'h2);
      stepCycle();
      checkOutput("t3_zC", 32'(ch_z), 32'h8);
      checkOutput("t3_ackD", 32'(ch_ack), 32'h8);
      stepCycle();
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t3_zD",   32'(ch_z),     32'h0);
      checkOutput("t3_cnt1", 32'(cntOf(1)), 32'd1);
      checkOutput("t3_cnt3", 32'(cntOf(3)), 32'd1);

      // Clear channel 2 while it is in the rise state, with a grant to channel 0 alongside.
      doReset();
      applyStimulus(4'b0100, 4'b0100, 4'b0000);
      #1; checkOutput("t4_ack_pre", 32'(ch_ack), 32'h4);
      stepCycle();
      checkOutput("t4_z_pre",   32'(ch_z[2]),  32'h1);
      checkOutput("t4_cnt_pre", 32'(cntOf(2)), 32'd1);
      applyStimulus(4'b0101, 4'b0101, 4'b0100);
      #1; checkOutput("t4_ack_clr", 32'(ch_ack), 32'h1);
      stepCycle();
      checkOutput("t4_z_clr",      32'(ch_z),     32'h1);
      checkOutput("t4_strobe_clr", 32'(z_strobe), 32'h1);
      checkOutput("t4_cnt_clr",    32'(cntOf(2)), 32'd0);
      checkOutput("t4_cnt0",       32'(cntOf(0)), 32'd1);
      applyStimulus(4'b0100, 4'b0100, 4'b0000);
      #1; checkOutput("t4_ack_post", 32'(ch_ack), 32'h4);
      stepCycle();
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t4_z_post",   32'(ch_z[2]),  32'h1);
      checkOutput("t4_cnt_post", 32'(cntOf(2)), 32'd1);

      // Saturation on the 2-bit counter instance: five rises on channel 0.
      doReset();
      for (int r = 0; r < 5; r++) begin
         s_valid = 4'b0001; s_w = 4'b0001; s_clr = 4'b0000;
         #1; checkOutput($sformatf("t5_ack%0d", r), 32'(s_ack), 32'h1);
         stepCycle();
         checkOutput($sformatf("t5_cnt%0d", r), 32'(s_cnt[1:0]), 32'((r + 1 > 3) ? 3 : r + 1));
         s_w = 4'b0000;
         stepCycle();
      end
      s_valid = 4'b0000;
      stepCycle();
      checkOutput("t5_cnt_final", 32'(s_cnt[1:0]), 32'd3);

      // Reset in the middle of traffic with channels in mixed states.
      doReset();
      applyStimulus(4'b1111, 4'b1111, 4'b0000);
      stepCycle();
      stepCycle();
      checkOutput("t6_z_pre", 32'(ch_z), 32'h3);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_ack_rst",    32'(ch_ack),   32'h0);
      checkOutput("t6_z_rst",      32'(ch_z),     32'h0);
      checkOutput("t6_strobe_rst", 32'(z_strobe), 32'h0);
      checkOutput("t6_cnt_rst",    rise_cnt,      32'h0);
      stepCycle();
      checkOutput("t6_ack_hold", 32'(ch_ack), 32'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("t6_ack_first", 32'(ch_ack), 32'h1);
      stepCycle();
      applyStimulus(4'b0000, 4'b0000, 4'b0000);
      checkOutput("t6_z_first", 32'(ch_z), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
